// File: rtl/configs_pkg.sv
// Shared definitions for the tile configuration path: FSM state encoding and
// default image geometry. Also used by the tile scan controller.
package configs_pkg;

   // Loader FSM states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2
   } cfg_state_e;

   // Default geometry of one configuration image
   localparam int CFG_WORD_W    = 32;
   localparam int CFG_NUM_WORDS = 16;

   // Word pointer width for an image of n words, never narrower than one bit
   function automatic int cfgPtrWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/configs_word_bank.sv
// Bank of NUM_WORDS configuration registers with a write enable per word and a
// flat image output. Word k is read and written at [k*WORD_W +: WORD_W].
module configs_word_bank #(
   parameter int WORD_W    = 32,
   parameter int NUM_WORDS = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_WORDS-1:0]        i_wordWe,
   input  logic [WORD_W*NUM_WORDS-1:0] i_data,
   output logic [WORD_W*NUM_WORDS-1:0] o_image
);

   logic [WORD_W-1:0] r_words [NUM_WORDS];

   // Each word loads its own slice of the flat input when its enable is set
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NUM_WORDS; k++) begin
            r_words[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_WORDS; k++) begin
            if (i_wordWe[k]) begin
               r_words[k] <= i_data[k*WORD_W +: WORD_W];
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_WORDS; g++) begin : g_flat
      assign o_image[g*WORD_W +: WORD_W] = r_words[g];
   end

endmodule

// File: rtl/configs_bank_loader.sv
// Clocked configuration bank loader for LUT tiles. Words stream into a shadow
// bank over a valid/ready port; a full image is copied to the active bank in a
// single cycle so io_configs_out never shows a partial image.
// Optional build macro: CONFIGS_PARITY_EN enables per-word even-parity checking;
// an image containing a bad word is never committed.
module configs_bank_loader
   import configs_pkg::*;
#(
   parameter int WORD_W    = CFG_WORD_W,
   parameter int NUM_WORDS = CFG_NUM_WORDS
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        io_start,
   input  logic                        io_abort,
   input  logic                        io_in_valid,
   output logic                        io_in_ready,
   input  logic [WORD_W-1:0]           io_d_in,
   input  logic                        io_in_parity,
   output logic                        io_busy,
   output logic                        io_done,
   output logic                        io_error,
   output logic [WORD_W*NUM_WORDS-1:0] io_configs_out
);

   localparam int PTR_W = cfgPtrWidth(NUM_WORDS);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_WORDS - 1);

   cfg_state_e r_state;
   cfg_state_e w_nextState;
   logic [PTR_W-1:0] r_ptr;
   logic r_done;
   logic w_take;
   logic w_commit;
   logic [NUM_WORDS-1:0] w_shadowWe;
   logic [WORD_W*NUM_WORDS-1:0] w_shadowData;
   logic [WORD_W*NUM_WORDS-1:0] w_shadowImage;

   // A word is accepted only on a handshake that is not cancelled by abort
   assign w_take       = io_in_valid && io_in_ready && !io_abort;
   assign w_shadowData = {NUM_WORDS{io_d_in}};
   assign io_done      = r_done;

   // Next-state logic and handshake outputs
   always_comb begin
      w_nextState = r_state;
      io_in_ready = 1'b0;
      io_busy     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (io_start) begin
               w_nextState = LOAD;
            end
         end
         LOAD: begin
            io_in_ready = 1'b1;
            io_busy     = 1'b1;
            if (io_abort) begin
               w_nextState = IDLE;
            end else if (w_take && (r_ptr == LAST_PTR)) begin
               w_nextState = COMMIT;
            end
         end
         COMMIT: begin
            io_busy     = 1'b1;
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Steer the accepted word into the shadow slot selected by the pointer
   always_comb begin
      w_shadowWe = '0;
      for (int k = 0; k < NUM_WORDS; k++) begin
         w_shadowWe[k] = w_take && (r_ptr == PTR_W'(k));
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Word pointer: cleared on start, advanced per handshake, held at the last word
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= '0;
      end else if ((r_state == IDLE) && io_start) begin
         r_ptr <= '0;
      end else if (w_take && (r_ptr != LAST_PTR)) begin
         r_ptr <= r_ptr + 1'b1;
      end
   end

`ifdef CONFIGS_PARITY_EN
   logic r_error;
   logic w_wordBad;

   assign w_wordBad = ^{io_d_in, io_in_parity};
   assign io_error  = r_error;
   assign w_commit  = (r_state == COMMIT) && !r_error;

   // Sticky parity error for the current load; a new start clears it
   always_ff @(posedge clk) begin
      if (reset) begin
         r_error <= 1'b0;
      end else if ((r_state == IDLE) && io_start) begin
         r_error <= 1'b0;
      end else if (w_take && w_wordBad) begin
         r_error <= 1'b1;
      end
   end
`else
   logic w_unusedParity;

   assign w_unusedParity = io_in_parity;
   assign io_error       = 1'b0;
   assign w_commit       = (r_state == COMMIT);
`endif

   // Done pulse lands together with the freshly committed image
   always_ff @(posedge clk) begin
      if (reset) begin
         r_done <= 1'b0;
      end else begin
         r_done <= w_commit;
      end
   end

   configs_word_bank #(
      .WORD_W    (WORD_W),
      .NUM_WORDS (NUM_WORDS)
   ) u_shadow (
      .clk      (clk),
      .reset    (reset),
      .i_wordWe (w_shadowWe),
      .i_data   (w_shadowData),
      .o_image  (w_shadowImage)
   );

   configs_word_bank #(
      .WORD_W    (WORD_W),
      .NUM_WORDS (NUM_WORDS)
   ) u_active (
      .clk      (clk),
      .reset    (reset),
      .i_wordWe ({NUM_WORDS{w_commit}}),
      .i_data   (w_shadowImage),
      .o_image  (io_configs_out)
   );

endmodule

// File: tb/tb_configs_bank_loader.sv
// Randomised bench for configs_bank_loader. The stimulus side pushes each image
// it expects to be committed; a monitor pops on every io_done and otherwise
// holds the active image steady.
module tb_configs_bank_loader;

   localparam int WORD_W    = 32;
   localparam int NUM_WORDS = 16;
   localparam int IMG_W     = WORD_W * NUM_WORDS;

   logic              clk = 1'b0;
   logic              reset;
   logic              io_start;
   logic              io_abort;
   logic              io_in_valid;
   logic              io_in_ready;
   logic [WORD_W-1:0] io_d_in;
   logic              io_in_parity;
   logic              io_busy;
   logic              io_done;
   logic              io_error;
   logic [IMG_W-1:0]  io_configs_out;

   int checks   = 0;
   int failures = 0;

   logic [IMG_W-1:0]  expQ[$];
   logic [IMG_W-1:0]  curImage;
   logic [WORD_W-1:0] words [NUM_WORDS];
   bit                monitorOn = 1'b0;
   bit                lastReset = 1'b0;

   configs_bank_loader #(
      .WORD_W    (WORD_W),
      .NUM_WORDS (NUM_WORDS)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .io_start       (io_start),
      .io_abort       (io_abort),
      .io_in_valid    (io_in_valid),
      .io_in_ready    (io_in_ready),
      .io_d_in        (io_d_in),
      .io_in_parity   (io_in_parity),
      .io_busy        (io_busy),
      .io_done        (io_done),
      .io_error       (io_error),
      .io_configs_out (io_configs_out)
   );

   always #5 clk = ~clk;

   // Hard stop in case something stalls beyond every bounded wait
   initial begin
      #400000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [IMG_W-1:0] actual,
                              input logic [IMG_W-1:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
      end
   endtask

   task automatic applyStimulus(input logic start, input logic abort, input logic valid,
                                input logic [WORD_W-1:0] data, input logic parity);
      io_start     = start;
      io_abort     = abort;
      io_in_valid  = valid;
      io_d_in      = data;
      io_in_parity = parity;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [IMG_W-1:0] packImage();
      logic [IMG_W-1:0] img;
      for (int k = 0; k < NUM_WORDS; k++) begin
         img[k*WORD_W +: WORD_W] = words[k];
      end
      return img;
   endfunction

   // Monitor: every io_done must match the oldest expected image; otherwise the
   // active image must not move. A reset empties the expectations.
   always @(negedge clk) begin
      if (monitorOn) begin
         if (lastReset) begin
            expQ.delete();
            curImage = '0;
         end
         if (io_done) begin
            if (expQ.size() == 0) begin
               checkOutput("done_without_commit", IMG_W'(io_done), '0);
            end else begin
               curImage = expQ.pop_front();
               checkOutput("commit_image", io_configs_out, curImage);
            end
         end else begin
            checkOutput("held_image", io_configs_out, curImage);
         end
      end
      lastReset = reset;
   end

   task automatic doStart();
      applyStimulus(1'b1, 1'b0, 1'b0, $urandom, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, $urandom, 1'b0);
      checkOutput("busy_after_start", IMG_W'(io_busy), IMG_W'(1));
      checkOutput("error_cleared_by_start", IMG_W'(io_error), '0);
   endtask

   // Load the words[] image: optional gaps between words, an optional bad-parity
   // word and an optional ignored start pulse before word startAt.
   task automatic loadImage(input int gapMin, input int gapMax, input int badIdx,
                            input int startAt);
      bit errModel;
      bit parityOn;
      int n;
`ifdef CONFIGS_PARITY_EN
      parityOn = 1'b1;
`else
      parityOn = 1'b0;
`endif
      errModel = 1'b0;
      doStart();
      for (int k = 0; k < NUM_WORDS; k++) begin
         if (k == startAt) begin
            applyStimulus(1'b1, 1'b0, 1'b0, $urandom, 1'b0);
            tick();
         end
         repeat ($urandom_range(gapMax, gapMin)) begin
            applyStimulus(1'b0, 1'b0, 1'b0, $urandom, 1'b0);
            tick();
         end
         n = 0;
         while (!io_in_ready && n < 20) begin
            tick();
            n++;
         end
         checkOutput("ready_in_load", IMG_W'(io_in_ready), IMG_W'(1));
         applyStimulus(1'b0, 1'b0, 1'b1, words[k], (^words[k]) ^ (k == badIdx));
         tick();
         if (k == badIdx && parityOn) begin
            errModel = 1'b1;
         end
         checkOutput("error_flag", IMG_W'(io_error), IMG_W'(errModel));
      end
      applyStimulus(1'b0, 1'b0, 1'b0, $urandom, 1'b0);
      if (!errModel) begin
         expQ.push_back(packImage());
      end
   endtask

   // Bounded wait for the loader to go back to IDLE, then let done drain
   task automatic waitIdle();
      int n;
      n = 0;
      while (io_busy && n < 8) begin
         tick();
         n++;
      end
      checkOutput("returned_idle", IMG_W'(io_busy), '0);
      tick();
      tick();
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      curImage = '0;
      tick();
      tick();
      reset = 1'b0;
      monitorOn = 1'b1;
      checkOutput("reset_image", io_configs_out, '0);
      checkOutput("reset_ready", IMG_W'(io_in_ready), '0);
      checkOutput("reset_busy", IMG_W'(io_busy), '0);
      checkOutput("reset_done", IMG_W'(io_done), '0);
      checkOutput("reset_error", IMG_W'(io_error), '0);

      // Back-to-back load, then check the exact commit timing
      $display("[TB] back-to-back load");
      for (int k = 0; k < NUM_WORDS; k++) words[k] = 32'h1000_0000 + k;
      loadImage(0, 0, -1, -1);
      checkOutput("commit_cycle_busy", IMG_W'(io_busy), IMG_W'(1));
      checkOutput("commit_cycle_ready", IMG_W'(io_in_ready), '0);
      checkOutput("commit_cycle_done", IMG_W'(io_done), '0);
      tick();
      checkOutput("done_pulse", IMG_W'(io_done), IMG_W'(1));
      checkOutput("done_cycle_idle", IMG_W'(io_busy), '0);
      checkOutput("done_cycle_image", io_configs_out, packImage());
      tick();
      checkOutput("done_single_cycle", IMG_W'(io_done), '0);

      // Valid toggling every other cycle
      $display("[TB] toggling valid");
      for (int k = 0; k < NUM_WORDS; k++) words[k] = 32'h2000_0000 + k;
      loadImage(1, 1, -1, -1);
      waitIdle();

      // Abort after 7 words with a word presented in the abort cycle
      $display("[TB] abort and restart");
      doStart();
      for (int k = 0; k < 7; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, $urandom, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 1'b1, 1'b1, $urandom, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, $urandom, 1'b0);
      checkOutput("abort_idle", IMG_W'(io_busy), '0);
      checkOutput("abort_ready", IMG_W'(io_in_ready), '0);
      repeat (3) tick();
      for (int k = 0; k < NUM_WORDS; k++) words[k] = 32'hA5A5_A5A5;
      loadImage(0, 0, -1, -1);
      waitIdle();

      // Valid in IDLE is ignored, start in LOAD is ignored
      $display("[TB] ignored start and valid");
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, $urandom, 1'b0);
         tick();
         checkOutput("idle_ready", IMG_W'(io_in_ready), '0);
         checkOutput("idle_busy", IMG_W'(io_busy), '0);
      end
      for (int k = 0; k < NUM_WORDS; k++) words[k] = $urandom;
      loadImage(0, 1, -1, 5);
      waitIdle();

      // Randomised images with random gaps
      $display("[TB] random loads");
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < NUM_WORDS; k++) words[k] = $urandom;
         loadImage(0, 2, -1, -1);
         waitIdle();
      end

      // Reset during the COMMIT cycle
      $display("[TB] reset during commit");
      for (int k = 0; k < NUM_WORDS; k++) words[k] = $urandom;
      loadImage(0, 0, -1, -1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("reset_commit_image", io_configs_out, '0);
      checkOutput("reset_commit_done", IMG_W'(io_done), '0);
      checkOutput("reset_commit_busy", IMG_W'(io_busy), '0);
      tick();
      checkOutput("reset_commit_no_done", IMG_W'(io_done), '0);
      tick();

`ifdef CONFIGS_PARITY_EN
      // Bad parity on word 3 blocks the commit; a new start clears the error
      $display("[TB] parity error");
      for (int k = 0; k < NUM_WORDS; k++) words[k] = $urandom;
      loadImage(0, 1, 3, -1);
      waitIdle();
      checkOutput("error_sticky", IMG_W'(io_error), IMG_W'(1));
      for (int k = 0; k < NUM_WORDS; k++) words[k] = $urandom;
      loadImage(0, 0, -1, -1);
      waitIdle();
`endif

      repeat (3) tick();
      checkOutput("pending_commits", IMG_W'(expQ.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
